stage_memory: RTL and testbench
===============================

# stage_memory

Memory stage of the five-stage pipeline, directly downstream of the execute stage. It owns the X/M pipeline latch, drives the multi-cycle data-memory handshake for `lw`/`sw`, stalls the front of the pipeline while a memory access is outstanding, and loads the M/W latch consumed by writeback. Bus timeouts and out-of-range addresses are turned into `$r30` exception writes.

## Interface
- `ADDR_W`, 12: data-memory word-address width.
- `TIMEOUT`, 16: maximum cycles in WAIT before a bus fault; must be ≥ 2.
- `clock` in 1: pipeline clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. 0 clears all state immediately.
- `x_insn` in 32: instruction leaving execute.
- `x_o` in 32: execute result (ALU result, jal link, setx value, or exception code).
- `x_b` in 32: bypassed rd value (store data).
- `x_exception` in 1: execute's `write_exception`.
- `dmem_rdata` in 32: read data. Valid in the cycle `dmem_ack`=1.
- `dmem_ack` in 1: access complete. Sampled only while `dmem_req`=1.
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 for `sw`, 0 for `lw`.
- `dmem_addr` out ADDR_W: `xm_o[ADDR_W-1:0]`.
- `dmem_wdata` out 32: `xm_b`.
- `stall` out 1: freeze F/D/X latches and the PC; execute holds its outputs.
- `o_xm_out` out 32: `xm_o`, used by execute's MX bypass.
- `xm_insn_out` out 32: latched X/M instruction, used by hazard/bypass control.
- `mw_insn` out 32: M/W instruction.
- `mw_o` out 32: M/W ALU result.
- `mw_d` out 32: M/W load data or result.
- `mw_exception` out 1: M/W writes the exception code to `$r30`.

## Operation
- Decode on `xm_insn`: `sw` = opcode 00111, `lw` = opcode 01000, `mem` = `sw | lw`.
- **X/M latch** (`xm_insn`, `xm_o`, `xm_b`, `xm_exc`)
  - Loads `x_*` on every edge with `stall`=0.
  - Holds when `stall`=1.
  - Reset value is all 0 (nop).
- **FSM states:** IDLE, WAIT.
- **IDLE**
  - Valid mem insn in X/M and `xm_o[31:ADDR_W]`==0: go to WAIT.
  - Valid mem insn in X/M, address out of range: do not request; complete as a fault with code 7. X/M advances with no stall.
  - Otherwise the insn passes to M/W in the next cycle.
- **WAIT**
  - Combinational outputs: `dmem_req`=1, `dmem_we`=`sw`, `dmem_addr`, `dmem_wdata`.
  - The cycle counter increments each cycle.
  - On `dmem_ack`=1: complete the access and return to IDLE. The counter clears.
  - If counter==`TIMEOUT-1` with no ack: fault with code 6, return to IDLE.
- **Stall:** `stall` = WAIT & ~`dmem_ack` & ~(counter==`TIMEOUT-1`). Combinational.
- **M/W latch**
  - On `stall`=0 it loads from X/M:
    - `mw_insn` = `xm_insn`; `mw_o` = `xm_o`.
    - `mw_d` = `dmem_rdata` for an acked `lw`, otherwise `xm_o`.
    - `mw_exception` = `xm_exc`.
  - On `stall`=1 it loads a bubble: insn 0, `mw_exception` 0.
- **Fault completion:** M/W loads insn 0, `mw_o`=`mw_d`=code (6 or 7), `mw_exception`=1. No register other than `$r30` is written, and `sw` data is never committed.
- **IDLE mem entry:** the mem insn appears in X/M in IDLE one cycle before WAIT. The FSM registers the transition, so `stall` is 0 in that IDLE cycle and X/M must not advance. This is enforced by treating "IDLE & valid in-range mem" as stalling: `stall` is also 1 in that cycle.

## Timing
- **Reset:** all outputs and latches are 0 and the FSM is IDLE. `dmem_req` drops asynchronously, even mid-WAIT. No write is retried after reset.
- **Non-mem latency:** X/M→M/W in 1 cycle, no stall.
- **Memory latency:** ack after k WAIT cycles (k≥1) gives `stall`=1 for k cycles: 1 IDLE-entry cycle plus k−1 WAIT cycles. M/W receives the result at the edge of the ack cycle.
- **Back-to-back mem insns:** the next mem insn loads into X/M on the ack edge, enters IDLE, and re-requests one cycle later. `dmem_req` drops for exactly 1 cycle between accesses.
- **Timeout:** occurs exactly `TIMEOUT` cycles after entering WAIT. A simultaneous ack on that cycle wins: normal completion, no fault.
- `dmem_ack` outside WAIT is ignored.
- `o_xm_out` for a `lw` is its address, not its data. A dependent insn in X must be stalled by the hazard unit. This block does not detect that hazard.

## Test plan
- **Reset:** assert `reset`=0 mid-WAIT. Required: `dmem_req` and `stall` drop the same cycle, all M/W outputs are 0, and after release the FSM is IDLE.
- **ALU passthrough:** `add` with `x_o`=0x1234, no mem. Required: `mw_o`=`mw_d`=0x1234 one cycle later, and `stall` never asserts.
- **Load:** `lw` to address 0x005, ack on the 3rd WAIT cycle with `dmem_rdata`=0xDEADBEEF. Required: `stall` high for 3 cycles, then `mw_d`=0xDEADBEEF, plus exactly 3 bubbles into M/W.
- **Store then load:** `sw` with `x_b`=0xA5 to address 0x010, immediate ack, followed directly by `lw`. Required: `dmem_we`=1 with `wdata`=0xA5, a 1-cycle `req` gap, then `dmem_we`=0.
- **Timeout:** `lw` with `TIMEOUT`=16 and no ack. Required: fault after 16 WAIT cycles with `mw_exception`=1 and `mw_d`=6. With ack on the 16th cycle instead: normal completion, no fault.
- **Out of range:** `sw` with `x_o`=0x00001000 (`ADDR_W`=12). Required: `dmem_req` stays 0, `mw_d`=7, `mw_exception`=1, no stall.

Source files
------------

// File: rtl/stage_memory.sv
// Memory stage: owns the X/M latch, runs the multi-cycle data-memory handshake for lw/sw,
// stalls the front end while an access is outstanding and loads the M/W latch for writeback.
module stage_memory #(
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       x_insn,
   input  logic [31:0]       x_o,
   input  logic [31:0]       x_b,
   input  logic              x_exception,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic              stall,
   output logic [31:0]       o_xm_out,
   output logic [31:0]       xm_insn_out,
   output logic [31:0]       mw_insn,
   output logic [31:0]       mw_o,
   output logic [31:0]       mw_d,
   output logic              mw_exception
);

   localparam int              CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [4:0]      OP_SW      = 5'b00111;
   localparam logic [4:0]      OP_LW      = 5'b01000;
   localparam logic [31:0]     CODE_BUS   = 32'd6;
   localparam logic [31:0]     CODE_RANGE = 32'd7;

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [31:0] xm_insn_q, xm_insn_d;
   logic [31:0] xm_o_q,    xm_o_d;
   logic [31:0] xm_b_q,    xm_b_d;
   logic        xm_exc_q,  xm_exc_d;

   logic [31:0] mw_insn_q, mw_insn_d;
   logic [31:0] mw_o_q,    mw_o_d;
   logic [31:0] mw_d_q,    mw_d_d;
   logic        mw_exc_q,  mw_exc_d;

   logic is_sw_s, is_lw_s, mem_s, in_range_s, in_wait_s;
   logic start_s, range_fault_s, last_s, bus_fault_s, acked_s, stall_s;

   // An insn already flagged by execute carries an exception code, not an address.
   assign is_sw_s       = (xm_insn_q[31:27] == OP_SW);
   assign is_lw_s       = (xm_insn_q[31:27] == OP_LW);
   assign mem_s         = (is_sw_s | is_lw_s) & ~xm_exc_q;
   assign in_range_s    = (xm_o_q[31:ADDR_W] == '0);
   assign in_wait_s     = (state_q == ST_WAIT);
   assign start_s       = ~in_wait_s & mem_s & in_range_s;
   assign range_fault_s = ~in_wait_s & mem_s & ~in_range_s;
   assign acked_s       = in_wait_s & dmem_ack;
   assign last_s        = in_wait_s & (cnt_q == CNT_LAST);
   assign bus_fault_s   = last_s & ~dmem_ack;
   // The IDLE entry cycle also stalls so X/M holds the insn the FSM is about to serve.
   assign stall_s       = start_s | (in_wait_s & ~dmem_ack & ~last_s);

   assign dmem_req     = in_wait_s;
   assign dmem_we      = in_wait_s & is_sw_s;
   assign dmem_addr    = xm_o_q[ADDR_W-1:0];
   assign dmem_wdata   = xm_b_q;
   assign stall        = stall_s;
   assign o_xm_out     = xm_o_q;
   assign xm_insn_out  = xm_insn_q;
   assign mw_insn      = mw_insn_q;
   assign mw_o         = mw_o_q;
   assign mw_d         = mw_d_q;
   assign mw_exception = mw_exc_q;

   // X/M next state: hold while stalled, otherwise take execute's outputs.
   always_comb begin
      xm_insn_d = xm_insn_q;
      xm_o_d    = xm_o_q;
      xm_b_d    = xm_b_q;
      xm_exc_d  = xm_exc_q;
      if (stall_s) begin
         xm_insn_d = xm_insn_q;
         xm_o_d    = xm_o_q;
         xm_b_d    = xm_b_q;
         xm_exc_d  = xm_exc_q;
      end else begin
         xm_insn_d = x_insn;
         xm_o_d    = x_o;
         xm_b_d    = x_b;
         xm_exc_d  = x_exception;
      end
   end

   // M/W next state: bubble, fault completion, or the X/M insn with its result.
   always_comb begin
      mw_insn_d = 32'd0;
      mw_o_d    = 32'd0;
      mw_d_d    = 32'd0;
      mw_exc_d  = 1'b0;
      if (stall_s) begin
         mw_insn_d = 32'd0;
         mw_exc_d  = 1'b0;
      end else if (bus_fault_s) begin
         mw_o_d   = CODE_BUS;
         mw_d_d   = CODE_BUS;
         mw_exc_d = 1'b1;
      end else if (range_fault_s) begin
         mw_o_d   = CODE_RANGE;
         mw_d_d   = CODE_RANGE;
         mw_exc_d = 1'b1;
      end else begin
         mw_insn_d = xm_insn_q;
         mw_o_d    = xm_o_q;
         mw_d_d    = (acked_s & is_lw_s) ? dmem_rdata : xm_o_q;
         mw_exc_d  = xm_exc_q;
      end
   end

   // Access FSM and WAIT cycle counter; an ack on the last cycle still completes normally.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (start_s) begin
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (dmem_ack || last_s) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else begin
                  state_q <= ST_WAIT;
                  cnt_q   <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // X/M pipeline latch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         xm_insn_q <= 32'd0;
         xm_o_q    <= 32'd0;
         xm_b_q    <= 32'd0;
         xm_exc_q  <= 1'b0;
      end else begin
         xm_insn_q <= xm_insn_d;
         xm_o_q    <= xm_o_d;
         xm_b_q    <= xm_b_d;
         xm_exc_q  <= xm_exc_d;
      end
   end

   // M/W pipeline latch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mw_insn_q <= 32'd0;
         mw_o_q    <= 32'd0;
         mw_d_q    <= 32'd0;
         mw_exc_q  <= 1'b0;
      end else begin
         mw_insn_q <= mw_insn_d;
         mw_o_q    <= mw_o_d;
         mw_d_q    <= mw_d_d;
         mw_exc_q  <= mw_exc_d;
      end
   end

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: expected M/W records are queued at issue and
// matched in order against non-bubble M/W outputs; a small memory model answers requests.
module tb_stage_memory;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] x_insn = 32'd0, x_o = 32'd0, x_b = 32'd0;
   logic        x_exception = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        dmem_ack = 1'b0;
   logic        dmem_req, dmem_we, stall, mw_exception;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_wdata, o_xm_out, xm_insn_out, mw_insn, mw_o, mw_d;

   stage_memory #(.ADDR_W(12), .TIMEOUT(16)) dut (
      .clock(clock), .reset(reset),
      .x_insn(x_insn), .x_o(x_o), .x_b(x_b), .x_exception(x_exception),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .stall(stall), .o_xm_out(o_xm_out), .xm_insn_out(xm_insn_out),
      .mw_insn(mw_insn), .mw_o(mw_o), .mw_d(mw_d), .mw_exception(mw_exception)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] o;
      logic [31:0] d;
      logic        exc;
   } mw_t;

   localparam logic [31:0] I_ADD = {5'b00000, 5'd3, 5'd1, 5'd2, 12'd0};
   localparam logic [31:0] I_LW  = {5'b01000, 5'd4, 5'd1, 17'd5};
   localparam logic [31:0] I_SW  = {5'b00111, 5'd6, 5'd1, 17'd16};

   mw_t         sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ack_delay = 0;
   logic [31:0] rdata_cfg = 32'd0;

   int          wc = 0, wait_len = 0, low_run = 1000, last_gap = 0;
   int          req_cycles = 0, wr_cnt = 0, rd_cnt = 0;
   logic        prev_req = 1'b0;
   logic [11:0] last_wr_addr = 12'd0;
   logic [31:0] last_wr_data = 32'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: acks on the ack_delay-th WAIT cycle (0 = never), records writes and gaps.
   always @(posedge clock) begin
      #2;
      if (dmem_req) begin
         if (!prev_req) begin
            last_gap = low_run;
            wc = 0;
         end
         wc++;
         wait_len = wc;
         req_cycles++;
         low_run = 0;
         if (ack_delay != 0 && wc == ack_delay) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata_cfg;
            if (dmem_we) begin
               wr_cnt++;
               last_wr_addr = dmem_addr;
               last_wr_data = dmem_wdata;
            end else begin
               rd_cnt++;
            end
         end else begin
            dmem_ack   = 1'b0;
            dmem_rdata = 32'h5A5A5A5A;
         end
      end else begin
         dmem_ack   = 1'b0;
         dmem_rdata = 32'h5A5A5A5A;
         low_run++;
      end
      prev_req = dmem_req;
   end

   // Scoreboard monitor: every non-bubble M/W record must match the oldest expectation.
   always @(negedge clock) begin
      mw_t e;
      if (reset && (mw_insn != 32'd0 || mw_exception)) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("mw_insn", mw_insn, e.insn);
            chk("mw_o", mw_o, e.o);
            chk("mw_d", mw_d, e.d);
            chk("mw_exc", {31'd0, mw_exception}, {31'd0, e.exc});
         end
      end
   end

   // Drive one insn into X until X/M accepts it; returns stalled cycles and bubbles seen.
   task automatic issue(input logic [31:0] insn, input logic [31:0] o, input logic [31:0] b,
                        input logic exc, output int stalls, output int bubbles);
      mw_t  e;
      logic is_mem, prev;
      x_insn = insn; x_o = o; x_b = b; x_exception = exc;
      is_mem = (insn[31:27] == 5'b00111 || insn[31:27] == 5'b01000) && !exc;
      if (insn != 32'd0 || exc) begin
         if (is_mem && o[31:12] != 20'd0) begin
            e.insn = 32'd0; e.o = 32'd7; e.d = 32'd7; e.exc = 1'b1;
         end else if (is_mem && (ack_delay == 0 || ack_delay > 16)) begin
            e.insn = 32'd0; e.o = 32'd6; e.d = 32'd6; e.exc = 1'b1;
         end else begin
            e.insn = insn; e.o = o; e.exc = exc;
            e.d = (is_mem && insn[31:27] == 5'b01000) ? rdata_cfg : o;
         end
         sb.push_back(e);
      end
      stalls = 0; bubbles = 0; prev = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clock);
         if (prev && mw_insn == 32'd0 && !mw_exception) bubbles++;
         prev = stall;
         if (!stall) break;
         stalls++;
         if (i == 63) chk("issue_bound", 32'(stalls), 32'd0);
      end
      @(posedge clock); #1;
      x_insn = 32'd0; x_o = 32'd0; x_b = 32'd0; x_exception = 1'b0;
   endtask

   initial begin
      int          s, bb, r0, w0, q0;
      logic [31:0] r;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mw_insn", mw_insn, 32'd0);
      chk("rst_mw_d", mw_d, 32'd0);
      chk("rst_xm_insn", xm_insn_out, 32'd0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;

      // ALU passthrough, exception passthrough and random ALU ops
      issue(I_ADD, 32'h1234, 32'h0, 1'b0, s, bb);
      chk("alu_stall0", 32'(s), 32'd0);
      issue(I_ADD | 32'h0001_0000, 32'hCAFE0001, 32'h0, 1'b1, s, bb);
      chk("alu_stall1", 32'(s), 32'd0);
      for (int i = 0; i < 4; i++) begin
         r = $urandom();
         issue({5'b00000, r[26:0]} | 32'h0040_0000, $urandom(), $urandom(), 1'b0, s, bb);
         chk("alu_stall_rnd", 32'(s), 32'd0);
      end

      // Load with ack on the 3rd WAIT cycle
      ack_delay = 3; rdata_cfg = 32'hDEADBEEF;
      issue(I_LW, 32'h005, 32'h0, 1'b0, s, bb);
      issue(I_ADD, 32'h0000_0111, 32'h0, 1'b0, s, bb);
      chk("lw_stall", 32'(s), 32'd3);
      chk("lw_bubbles", 32'(bb), 32'd3);

      // Store then load back to back, immediate ack
      ack_delay = 1; rdata_cfg = 32'h0000_00A5;
      w0 = wr_cnt; r0 = rd_cnt;
      issue(I_SW, 32'h010, 32'h0000_00A5, 1'b0, s, bb);
      issue(I_LW, 32'h010, 32'h0, 1'b0, s, bb);
      chk("sw_stall", 32'(s), 32'd1);
      issue(I_ADD, 32'h0000_0222, 32'h0, 1'b0, s, bb);
      chk("lw2_stall", 32'(s), 32'd1);
      chk("sw_count", 32'(wr_cnt - w0), 32'd1);
      chk("sw_addr", {20'd0, last_wr_addr}, 32'h010);
      chk("sw_data", last_wr_data, 32'h0000_00A5);
      chk("lw2_read", 32'(rd_cnt - r0), 32'd1);
      chk("req_gap", 32'(last_gap), 32'd1);

      // Timeout with no ack, then ack on the final WAIT cycle
      ack_delay = 0;
      issue(I_LW, 32'h020, 32'h0, 1'b0, s, bb);
      issue(I_ADD, 32'h0000_0333, 32'h0, 1'b0, s, bb);
      chk("to_stall", 32'(s), 32'd16);
      chk("to_wait_len", 32'(wait_len), 32'd16);
      ack_delay = 16; rdata_cfg = 32'h0BADF00D;
      issue(I_LW, 32'h021, 32'h0, 1'b0, s, bb);
      issue(I_ADD, 32'h0000_0444, 32'h0, 1'b0, s, bb);
      chk("ack16_stall", 32'(s), 32'd16);

      // Out-of-range store: no request, no write, no stall
      q0 = req_cycles; w0 = wr_cnt;
      issue(I_SW, 32'h0000_1000, 32'h0000_0055, 1'b0, s, bb);
      issue(I_ADD, 32'h0000_0555, 32'h0, 1'b0, s, bb);
      chk("oor_stall", 32'(s), 32'd0);
      chk("oor_req", 32'(req_cycles - q0), 32'd0);
      chk("oor_write", 32'(wr_cnt - w0), 32'd0);

      // Reset asserted mid-WAIT
      ack_delay = 0;
      issue(I_LW, 32'h030, 32'h0, 1'b0, s, bb);
      @(posedge clock); @(posedge clock); #3;
      chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
      chk("pre_rst_stall", {31'd0, stall}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, dmem_req}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall}, 32'd0);
      chk("mid_rst_mw_insn", mw_insn, 32'd0);
      chk("mid_rst_mw_o", mw_o, 32'd0);
      chk("mid_rst_mw_d", mw_d, 32'd0);
      chk("mid_rst_mw_exc", {31'd0, mw_exception}, 32'd0);
      sb.delete();
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
      chk("post_rst_stall", {31'd0, stall}, 32'd0);
      issue(I_ADD, 32'h0000_0666, 32'h0, 1'b0, s, bb);
      chk("post_rst_alu", 32'(s), 32'd0);

      issue(32'd0, 32'd0, 32'd0, 1'b0, s, bb);
      issue(32'd0, 32'd0, 32'd0, 1'b0, s, bb);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
